alu_result_stage: RTL and testbench

- Execute-stage back end that sits directly downstream of the 16-bit ALU.
- Each accepted entry captures the ALU result and flags (ZF, OF, SF, CF) plus writeback control.
- Resolves set-condition and branch-condition instructions, then holds the entry in a 2-entry skid buffer feeding the memory stage.
- Valid/ready handshake on both sides, with a synchronous flush for branch mispredict.

---
 rtl/alu_result_stage.sv | 128 ++++++++++++
 tb/tb_alu_result_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage
// Execute-stage back end behind the 16-bit ALU. Each accepted entry captures
// the ALU result, the flags {zf,of,sf,cf} and writeback control. Set/branch
// conditions are resolved on entry. The entry then sits in a 2-deep skid
// FIFO that feeds the memory stage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready ignores out_ready)
//   alu_out, zf/of/sf/cf ALU result and flags
//   cond_sel            result/condition select
//   wr_en_in, wr_reg_in writeback control
//   flush               drop everything buffered and incoming
//   out_valid/out_ready downstream handshake
//   out_result, out_wr_en, out_wr_reg, out_taken, out_flags
//                       head entry fields, all zero while empty
module alu_result_stage #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    alu_out,
  input  logic                zf,
  input  logic                of,
  input  logic                sf,
  input  logic                cf,
  input  logic [3:0]          cond_sel,
  input  logic                wr_en_in,
  input  logic [REG_BITS-1:0] wr_reg_in,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic                out_wr_en,
  output logic [REG_BITS-1:0] out_wr_reg,
  output logic                out_taken,
  output logic [3:0]          out_flags
);

  typedef struct packed {
    logic [WIDTH-1:0]    result;
    logic                wr_en;
    logic [REG_BITS-1:0] wr_reg;
    logic                taken;
    logic [3:0]          flags;
  } entry_t;

  // f is {zf,of,sf,cf}; branches never write back.
  function automatic entry_t resolve(
    input logic [WIDTH-1:0]    a,
    input logic [3:0]          f,
    input logic [3:0]          sel,
    input logic                we,
    input logic [REG_BITS-1:0] r
  );
    entry_t e;
    logic   lt;
    lt       = f[1] ^ f[2];
    e.result = a;
    e.wr_en  = we;
    e.wr_reg = r;
    e.taken  = 1'b0;
    e.flags  = f;
    case (sel)
      4'b0001: e.result = {{(WIDTH-1){1'b0}}, f[3]};
      4'b0010: e.result = {{(WIDTH-1){1'b0}}, lt};
      4'b0011: e.result = {{(WIDTH-1){1'b0}}, lt | f[3]};
      4'b0100: e.result = {{(WIDTH-1){1'b0}}, f[0]};
      4'b0101: begin e.taken = f[3];  e.wr_en = 1'b0; end
      4'b0110: begin e.taken = ~f[3]; e.wr_en = 1'b0; end
      4'b0111: begin e.taken = f[1];  e.wr_en = 1'b0; end
      4'b1000: begin e.taken = ~f[1]; e.wr_en = 1'b0; end
      default: ;
    endcase
    return e;
  endfunction

  entry_t     entry_p1 [2];
  logic       head_p1;
  logic [1:0] count_p1;
  logic       push;
  logic       pop;
  logic       tail;
  entry_t     head_e;

  assign in_ready  = !rst && (count_p1 != 2'd2);
  assign out_valid = (count_p1 != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Pushes only occur at count 0 or 1, so the free slot is head or head^1.
  assign tail      = head_p1 ^ count_p1[0];

  // Stage p1: resolve on push, store into the skid FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p1    <= 2'd0;
      head_p1     <= 1'b0;
      entry_p1[0] <= '0;
      entry_p1[1] <= '0;
    end else if (flush) begin
      count_p1 <= 2'd0;
      head_p1  <= 1'b0;
    end else begin
      if (push)
        entry_p1[tail] <= resolve(alu_out, {zf, of, sf, cf}, cond_sel,
                                  wr_en_in, wr_reg_in);
      if (pop)
        head_p1 <= ~head_p1;
      case ({push, pop})
        2'b10:   count_p1 <= count_p1 + 2'd1;
        2'b01:   count_p1 <= count_p1 - 2'd1;
        default: count_p1 <= count_p1;
      endcase
    end
  end

  // Stage out: head entry, masked to zero while empty
  assign head_e     = out_valid ? entry_p1[head_p1] : '0;
  assign out_result = head_e.result;
  assign out_wr_en  = head_e.wr_en;
  assign out_wr_reg = head_e.wr_reg;
  assign out_taken  = head_e.taken;
  assign out_flags  = head_e.flags;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  localparam int WIDTH    = 16;
  localparam int REG_BITS = 3;

  logic                clk = 1'b0;
  logic                rst, in_valid, in_ready;
  logic [WIDTH-1:0]    alu_out;
  logic                zf, of, sf, cf;
  logic [3:0]          cond_sel;
  logic                wr_en_in;
  logic [REG_BITS-1:0] wr_reg_in;
  logic                flush, out_valid, out_ready;
  logic [WIDTH-1:0]    out_result;
  logic                out_wr_en;
  logic [REG_BITS-1:0] out_wr_reg;
  logic                out_taken;
  logic [3:0]          out_flags;

  alu_result_stage #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .zf(zf), .of(of), .sf(sf), .cf(cf),
    .cond_sel(cond_sel), .wr_en_in(wr_en_in), .wr_reg_in(wr_reg_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_wr_en(out_wr_en), .out_wr_reg(out_wr_reg),
    .out_taken(out_taken), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]    res;
    logic                wr_en;
    logic [REG_BITS-1:0] dst;
    logic                taken;
    logic [3:0]          flags;
  } exp_t;

  exp_t q[$];
  exp_t stim_exp;
  exp_t front;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 0;
  bit   do_push, do_pop;

  // Reference behaviour: what the instruction means, expressed directly.
  function automatic exp_t model(logic [WIDTH-1:0] a, logic z, logic o,
                                 logic s, logic c, logic [3:0] sel,
                                 logic we, logic [REG_BITS-1:0] r);
    exp_t e;
    bit   less;
    less    = (s != o);
    e.res   = a;
    e.wr_en = we;
    e.dst   = r;
    e.taken = 1'b0;
    e.flags = {z, o, s, c};
    if (sel == 4'd1) e.res = z ? 16'd1 : 16'd0;
    if (sel == 4'd2) e.res = less ? 16'd1 : 16'd0;
    if (sel == 4'd3) e.res = (less || z) ? 16'd1 : 16'd0;
    if (sel == 4'd4) e.res = c ? 16'd1 : 16'd0;
    if (sel >= 4'd5 && sel <= 4'd8) begin
      e.wr_en = 1'b0;
      if (sel == 4'd5) e.taken = z;
      if (sel == 4'd6) e.taken = !z;
      if (sel == 4'd7) e.taken = s;
      if (sel == 4'd8) e.taken = !s;
    end
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare presented head with the scoreboard, then advance the
  // scoreboard for the coming edge from the observed handshakes.
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, (!rst && q.size() < 2)});
      check("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
      if (q.size() != 0) begin
        front = q[0];
        check("out_result", {16'd0, out_result}, {16'd0, front.res});
        check("out_wr_en", {31'd0, out_wr_en}, {31'd0, front.wr_en});
        check("out_wr_reg", {29'd0, out_wr_reg}, {29'd0, front.dst});
        check("out_taken", {31'd0, out_taken}, {31'd0, front.taken});
        check("out_flags", {28'd0, out_flags}, {28'd0, front.flags});
      end else begin
        check("idle_zero", {7'd0, out_result, out_wr_en, out_wr_reg, out_taken, out_flags}, 32'd0);
      end
      do_pop  = out_valid && out_ready;
      do_push = in_valid && in_ready;
      if (rst || flush) q.delete();
      else begin
        if (do_pop && q.size() > 0) void'(q.pop_front());
        if (do_push) q.push_back(stim_exp);
      end
    end
  end

  task automatic drive(logic v, logic [WIDTH-1:0] a, logic [3:0] sel,
                       logic z, logic o, logic s, logic c, logic we,
                       logic [REG_BITS-1:0] r, logic ordy, logic fl = 1'b0,
                       logic rs = 1'b0);
    @(posedge clk); #1;
    in_valid = v; alu_out = a; cond_sel = sel; zf = z; of = o; sf = s; cf = c;
    wr_en_in = we; wr_reg_in = r; out_ready = ordy; flush = fl; rst = rs;
    stim_exp = model(a, z, o, s, c, sel, we, r);
  endtask

  task automatic idle(logic ordy, int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 4'd0, 0, 0, 0, 0, 1'b0, 3'd0, ordy);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; alu_out = 0; cond_sel = 0; zf = 0; of = 0;
    sf = 0; cf = 0; wr_en_in = 0; wr_reg_in = 0; flush = 0; out_ready = 0;
    stim_exp = model(16'h0, 0, 0, 0, 0, 4'd0, 1'b0, 3'd0);
    @(posedge clk); #1;
    mon_en = 1;
    @(posedge clk); #1;
    rst = 1'b0;

    // single pass-through push
    drive(1, 16'h1234, 4'd0, 0, 0, 0, 0, 1, 3'd3, 1);
    idle(1, 2);

    // condition resolution
    drive(1, 16'h8000, 4'd2, 0, 0, 1, 0, 1, 3'd1, 1);
    drive(1, 16'h8000, 4'd2, 0, 1, 1, 0, 1, 3'd1, 1);
    drive(1, 16'h0000, 4'd3, 1, 0, 0, 0, 1, 3'd2, 1);
    drive(1, 16'h0005, 4'd4, 0, 0, 0, 1, 1, 3'd4, 1);
    drive(1, 16'h0000, 4'd5, 1, 0, 0, 0, 1, 3'd5, 1);
    drive(1, 16'hF00F, 4'd8, 0, 0, 1, 0, 1, 3'd6, 1);
    drive(1, 16'h0042, 4'd6, 0, 0, 0, 0, 1, 3'd7, 1);
    drive(1, 16'hC001, 4'd7, 0, 0, 1, 1, 1, 3'd0, 1);
    drive(1, 16'h7777, 4'd11, 1, 1, 1, 1, 1, 3'd2, 1);
    idle(1, 2);

    // backpressure: fill, stall, then drain
    drive(1, 16'hAAAA, 4'd0, 0, 0, 1, 0, 1, 3'd1, 0);
    drive(1, 16'hBBBB, 4'd0, 0, 0, 1, 0, 1, 3'd2, 0);
    idle(0, 3);
    idle(1, 3);

    // sustained push/pop at one entry
    for (int i = 1; i <= 4; i++)
      drive(1, 16'(i), 4'd0, 0, 0, 0, 0, 1, 3'(i), 1);
    idle(1, 2);

    // flush while full with a concurrent push
    drive(1, 16'h1111, 4'd0, 0, 0, 0, 0, 1, 3'd1, 0);
    drive(1, 16'h2222, 4'd0, 0, 0, 0, 0, 1, 3'd2, 0);
    drive(1, 16'hCCCC, 4'd0, 0, 0, 0, 0, 1, 3'd3, 1, 1'b1);
    idle(1, 2);

    // reset mid-stream with one entry held and in_valid high
    drive(1, 16'h5555, 4'd0, 0, 0, 0, 0, 1, 3'd5, 0);
    drive(1, 16'h6666, 4'd0, 0, 0, 0, 0, 1, 3'd6, 1, 1'b0, 1'b1);
    idle(1, 2);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) == 0));
    idle(1, 4);

    @(posedge clk); #1;
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
